// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Groups every handshake and bus signal of the SRAM arbiter into one bundle.
//   clk and rst are not part of it; they are plain ports on the arbiter.
//
//   Requester side (fetch port, data port):
//     if_req / if_addr / if_rdata / if_ack
//     mem_req / mem_we / mem_addr / mem_wdata / mem_rdata / mem_ack
//   SRAM controller side:
//     bus_addr / read_op / write_op / bus_data_write / bus_data_read
//
//   Handshake semantics: a requester raises *_req and holds it, together with
//   its address/op/write data, until it sees a one-cycle *_ack. Read data is
//   valid only in the ack cycle. Towards the controller, read_op / write_op
//   are single-cycle strobes, and bus_data_read is valid one cycle after
//   read_op.
//
//   Modports:
//     slave  - the arbiter's view
//     master - the view of the surroundings (requesters plus SRAM controller)
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  read_op;
    logic                  write_op;
    logic [DATA_WIDTH-1:0] bus_data_write;
    logic [DATA_WIDTH-1:0] bus_data_read;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_data_read,
        output if_rdata, if_ack, mem_rdata, mem_ack,
        output bus_addr, read_op, write_op, bus_data_write
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_data_read,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
        input  bus_addr, read_op, write_op, bus_data_write
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one SRAM controller between the read-only instruction-fetch port
//   and the read/write data port. Each access runs as IDLE -> ISSUE -> RESP:
//   the winner is latched in IDLE, the bus strobe fires in ISSUE, and the ack
//   plus read data are returned in RESP.
//
//   Ports:
//     clk       - system clock, rising edge
//     rst       - asynchronous, active-high reset
//     sif       - sram_arbiter_if.slave (requester ports and controller bus)
//     dbg_state - current FSM state (0 = IDLE, 1 = ISSUE, 2 = RESP)
//
//   Configuration:
//     SRAM_ARB_RR_EN - when defined, ties are broken round-robin through a
//                      one-bit preference pointer that starts on IF after
//                      reset. When undefined, the data port always wins a
//                      tie and no pointer exists.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    sram_arbiter_if.slave sif,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched transaction. owner_q: 0 = fetch port, 1 = data port.
    logic                  owner_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic any_req;
    logic grant_mem;

    assign any_req = sif.if_req | sif.mem_req;

`ifdef SRAM_ARB_RR_EN
    // pref_mem_q names the port that wins the next tie. It moves to the
    // losing port each time a tie is resolved, which alternates the grants.
    logic pref_mem_q;

    assign grant_mem = sif.mem_req & (~sif.if_req | pref_mem_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_mem_q <= 1'b0;
        end else if (state_q == IDLE && sif.if_req && sif.mem_req) begin
            pref_mem_q <= ~grant_mem;
        end
    end
`else
    assign grant_mem = sif.mem_req;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction latch. Requests are only looked at in IDLE, so later changes
    // to the requester's address or data cannot leak into an access in flight.
    // The fetch port has no write data, so a fetch grant latches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q <= grant_mem;
            we_q    <= grant_mem & sif.mem_we;
            addr_q  <= grant_mem ? sif.mem_addr  : sif.if_addr;
            wdata_q <= grant_mem ? sif.mem_wdata : '0;
        end
    end

    // Output logic. Strobes and acks decode purely from state, so an
    // asynchronous reset removes them immediately.
    always_comb begin
        sif.bus_addr       = addr_q;
        sif.bus_data_write = wdata_q;
        sif.read_op        = 1'b0;
        sif.write_op       = 1'b0;
        sif.if_ack         = 1'b0;
        sif.mem_ack        = 1'b0;
        sif.if_rdata       = '0;
        sif.mem_rdata      = '0;
        case (state_q)
            ISSUE: begin
                sif.read_op  = ~we_q;
                sif.write_op = we_q;
            end
            RESP: begin
                if (owner_q) begin
                    sif.mem_ack   = 1'b1;
                    sif.mem_rdata = sif.bus_data_read;
                end else begin
                    sif.if_ack    = 1'b1;
                    sif.if_rdata  = sif.bus_data_read;
                end
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. A byte-wide SRAM model answers the
//   bus strobes; every test task drives requests, pushes the expected
//   {owner, address, data} into exp_q and pops/compares when the arbiter
//   strobes and acks. Inputs change and outputs are sampled on the falling
//   clock edge.
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int EW = 1 + AW + DW;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sif       (sif),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRAM model (256 bytes, little endian) ----------------
    logic [7:0]    sram [0:255];
    logic [7:0]    a;
    logic          poke_en;
    logic [7:0]    poke_addr;
    logic [DW-1:0] poke_data;

    assign a = sif.bus_addr[7:0];

    always @(posedge clk) begin
        if (poke_en) begin
            sram[poke_addr]              <= poke_data[7:0];
            sram[8'(poke_addr + 8'd1)]   <= poke_data[15:8];
            sram[8'(poke_addr + 8'd2)]   <= poke_data[23:16];
            sram[8'(poke_addr + 8'd3)]   <= poke_data[31:24];
        end
        if (sif.read_op) begin
            sif.bus_data_read <= {sram[8'(a + 8'd3)], sram[8'(a + 8'd2)],
                                  sram[8'(a + 8'd1)], sram[a]};
        end
        if (sif.write_op) begin
            sram[a]            <= sif.bus_data_write[7:0];
            sram[8'(a + 8'd1)] <= sif.bus_data_write[15:8];
            sram[8'(a + 8'd2)] <= sif.bus_data_write[23:16];
            sram[8'(a + 8'd3)] <= sif.bus_data_write[31:24];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int vectors;
    int miscompares;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] addr, input logic [DW-1:0] data);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic idle_inputs();
        sif.if_req    = 1'b0;
        sif.if_addr   = '0;
        sif.mem_req   = 1'b0;
        sif.mem_we    = 1'b0;
        sif.mem_addr  = '0;
        sif.mem_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        vectors++; if ({sif.read_op, sif.write_op} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes: got %b want 00", {sif.read_op, sif.write_op}); end
        vectors++; if ({sif.if_ack, sif.mem_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks: got %b want 00", {sif.if_ack, sif.mem_ack}); end
        vectors++; if (sif.bus_addr !== '0) begin miscompares++; $display("FAIL reset_bus_addr: got %h want 0", sif.bus_addr); end
        vectors++; if (sif.bus_data_write !== '0) begin miscompares++; $display("FAIL reset_bus_wdata: got %h want 0", sif.bus_data_write); end
        vectors++; if ({sif.if_rdata, sif.mem_rdata} !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 0", sif.if_rdata, sif.mem_rdata); end
        rst = 1'b0;
        step();
        step();
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL idle_no_req: got %0d want 0", dbg_state); end
    endtask

    task automatic test_lone_fetch();
        logic [EW-1:0] e;
        poke(8'h10, 32'hDEADBEEF);
        sif.if_addr = 20'h10;
        sif.if_req  = 1'b1;
        exp_q.push_back({1'b0, 20'h10, 32'hDEADBEEF});
        step();
        e = exp_q.pop_front();
        vectors++; if ({sif.read_op, sif.write_op} !== 2'b10) begin miscompares++; $display("FAIL fetch_strobe: got %b want 10", {sif.read_op, sif.write_op}); end
        vectors++; if (sif.bus_addr !== e[DW+AW-1:DW]) begin miscompares++; $display("FAIL fetch_bus_addr: got %h want %h", sif.bus_addr, e[DW+AW-1:DW]); end
        vectors++; if ({sif.if_ack, sif.mem_ack} !== 2'b00) begin miscompares++; $display("FAIL fetch_early_ack: got %b want 00", {sif.if_ack, sif.mem_ack}); end
        step();
        vectors++; if ({sif.if_ack, sif.mem_ack} !== 2'b10) begin miscompares++; $display("FAIL fetch_ack: got %b want 10", {sif.if_ack, sif.mem_ack}); end
        vectors++; if (sif.if_rdata !== e[DW-1:0]) begin miscompares++; $display("FAIL fetch_rdata: got %h want %h", sif.if_rdata, e[DW-1:0]); end
        vectors++; if ({sif.read_op, sif.write_op} !== 2'b00) begin miscompares++; $display("FAIL fetch_strobe_width: got %b want 00", {sif.read_op, sif.write_op}); end
        vectors++; if (sif.mem_rdata !== '0) begin miscompares++; $display("FAIL fetch_nonowner_rdata: got %h want 0", sif.mem_rdata); end
        sif.if_req = 1'b0;
        step();
        vectors++; if (sif.if_ack !== 1'b0 || sif.if_rdata !== '0) begin miscompares++; $display("FAIL fetch_ack_pulse: got %b/%h want 0/0", sif.if_ack, sif.if_rdata); end
        vectors++; if (sif.bus_addr !== 20'h10) begin miscompares++; $display("FAIL fetch_addr_hold: got %h want 10", sif.bus_addr); end
    endtask

    task automatic test_lone_write();
        logic [EW-1:0] e;
        sif.mem_we    = 1'b1;
        sif.mem_addr  = 20'h20;
        sif.mem_wdata = 32'h12345678;
        sif.mem_req   = 1'b1;
        exp_q.push_back({1'b1, 20'h20, 32'h12345678});
        step();
        e = exp_q.pop_front();
        vectors++; if ({sif.read_op, sif.write_op} !== 2'b01) begin miscompares++; $display("FAIL write_strobe: got %b want 01", {sif.read_op, sif.write_op}); end
        vectors++; if (sif.bus_addr !== e[DW+AW-1:DW]) begin miscompares++; $display("FAIL write_bus_addr: got %h want %h", sif.bus_addr, e[DW+AW-1:DW]); end
        vectors++; if (sif.bus_data_write !== e[DW-1:0]) begin miscompares++; $display("FAIL write_bus_wdata: got %h want %h", sif.bus_data_write, e[DW-1:0]); end
        step();
        vectors++; if ({sif.if_ack, sif.mem_ack} !== 2'b01) begin miscompares++; $display("FAIL write_ack: got %b want 01", {sif.if_ack, sif.mem_ack}); end
        vectors++; if (sif.write_op !== 1'b0) begin miscompares++; $display("FAIL write_strobe_width: got %b want 0", sif.write_op); end
        sif.mem_req = 1'b0;
        sif.mem_we  = 1'b0;
        step();
        vectors++; if (sif.mem_ack !== 1'b0) begin miscompares++; $display("FAIL write_ack_pulse: got %b want 0", sif.mem_ack); end
        vectors++; if ({sram[8'h20], sram[8'h21], sram[8'h22], sram[8'h23]} !== 32'h78563412) begin
            miscompares++; $display("FAIL write_sram_bytes: got %h want 78563412", {sram[8'h20], sram[8'h21], sram[8'h22], sram[8'h23]});
        end
    endtask

    task automatic test_stale_inputs();
        logic [EW-1:0] e;
        logic [DW-1:0] d8, dc;
        d8 = $urandom;
        dc = d8 ^ DW'($urandom_range(1, 255));
        poke(8'h08, d8);
        poke(8'h0C, dc);
        sif.mem_we   = 1'b0;
        sif.mem_addr = 20'h8;
        sif.mem_req  = 1'b1;
        exp_q.push_back({1'b1, 20'h8, d8});
        step();
        e = exp_q.pop_front();
        sif.mem_addr = 20'hC;
        #1;
        vectors++; if (sif.bus_addr !== e[DW+AW-1:DW]) begin miscompares++; $display("FAIL stale_bus_addr: got %h want %h", sif.bus_addr, e[DW+AW-1:DW]); end
        vectors++; if (sif.read_op !== 1'b1) begin miscompares++; $display("FAIL stale_read_op: got %b want 1", sif.read_op); end
        step();
        vectors++; if (sif.mem_ack !== 1'b1 || sif.mem_rdata !== e[DW-1:0]) begin
            miscompares++; $display("FAIL stale_rdata: got ack %b data %h want 1 %h", sif.mem_ack, sif.mem_rdata, e[DW-1:0]);
        end
        vectors++; if (sif.if_rdata !== '0) begin miscompares++; $display("FAIL stale_nonowner_rdata: got %h want 0", sif.if_rdata); end
        sif.mem_req = 1'b0;
        step();
    endtask

    // Both ports request in the same cycle; the winner drops its request at
    // its ack, the loser is then served.
    task automatic test_contention_pair();
        logic [EW-1:0] e;
        logic          got_ack, other_ack;
        logic [DW-1:0] got_data;
        apply_reset();
        poke(8'h00, 32'h11111111);
        poke(8'h04, 32'h22222222);
        sif.if_addr  = 20'h0;
        sif.mem_addr = 20'h4;
        sif.mem_we   = 1'b0;
        sif.if_req   = 1'b1;
        sif.mem_req  = 1'b1;
`ifdef SRAM_ARB_RR_EN
        exp_q.push_back({1'b0, 20'h0, 32'h11111111});
        exp_q.push_back({1'b1, 20'h4, 32'h22222222});
`else
        exp_q.push_back({1'b1, 20'h4, 32'h22222222});
        exp_q.push_back({1'b0, 20'h0, 32'h11111111});
`endif
        for (int g = 0; g < 2; g++) begin
            step();
            e = exp_q.pop_front();
            vectors++; if (sif.read_op !== 1'b1 || sif.bus_addr !== e[DW+AW-1:DW]) begin
                miscompares++; $display("FAIL pair_issue_%0d: got read_op %b addr %h want 1 %h", g, sif.read_op, sif.bus_addr, e[DW+AW-1:DW]);
            end
            step();
            got_ack   = e[EW-1] ? sif.mem_ack : sif.if_ack;
            other_ack = e[EW-1] ? sif.if_ack  : sif.mem_ack;
            got_data  = e[EW-1] ? sif.mem_rdata : sif.if_rdata;
            vectors++; if ({got_ack, other_ack} !== 2'b10) begin
                miscompares++; $display("FAIL pair_ack_%0d: got owner %b other %b want 1 0 (owner mem=%b)", g, got_ack, other_ack, e[EW-1]);
            end
            vectors++; if (got_data !== e[DW-1:0]) begin miscompares++; $display("FAIL pair_rdata_%0d: got %h want %h", g, got_data, e[DW-1:0]); end
            if (e[EW-1]) sif.mem_req = 1'b0;
            else         sif.if_req  = 1'b0;
            step();
        end
    endtask

    // Both ports keep requesting for four grants.
    task automatic test_continuous();
        logic [EW-1:0] e;
        logic [DW-1:0] d_if, d_mem, got_data;
        logic          owner, got_ack, other_ack;
        apply_reset();
        d_if  = $urandom;
        d_mem = $urandom;
        poke(8'h40, d_if);
        poke(8'h44, d_mem);
        sif.if_addr  = 20'h40;
        sif.mem_addr = 20'h44;
        sif.mem_we   = 1'b0;
        sif.if_req   = 1'b1;
        sif.mem_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
            owner = (k % 2) == 1;
`else
            owner = 1'b1;
`endif
            exp_q.push_back(owner ? {1'b1, 20'h44, d_mem} : {1'b0, 20'h40, d_if});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            e = exp_q.pop_front();
            vectors++; if (sif.read_op !== 1'b1 || sif.bus_addr !== e[DW+AW-1:DW]) begin
                miscompares++; $display("FAIL cont_issue_%0d: got read_op %b addr %h want 1 %h", k, sif.read_op, sif.bus_addr, e[DW+AW-1:DW]);
            end
            step();
            got_ack   = e[EW-1] ? sif.mem_ack : sif.if_ack;
            other_ack = e[EW-1] ? sif.if_ack  : sif.mem_ack;
            got_data  = e[EW-1] ? sif.mem_rdata : sif.if_rdata;
            vectors++; if ({got_ack, other_ack} !== 2'b10 || got_data !== e[DW-1:0]) begin
                miscompares++; $display("FAIL cont_resp_%0d: got ack %b/%b data %h want 1/0 %h", k, got_ack, other_ack, got_data, e[DW-1:0]);
            end
            step();
            vectors++; if (dbg_state !== 2'd0 || sif.read_op !== 1'b0) begin
                miscompares++; $display("FAIL cont_idle_%0d: got state %0d read_op %b want 0 0", k, dbg_state, sif.read_op);
            end
        end
        sif.if_req  = 1'b0;
        sif.mem_req = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [EW-1:0] e;
        logic [DW-1:0] d;
        d = $urandom;
        poke(8'h30, d);
        sif.if_addr = 20'h30;
        sif.if_req  = 1'b1;
        exp_q.push_back({1'b0, 20'h30, d});
        step();
        vectors++; if (sif.read_op !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_read_op: got %b want 1", sif.read_op); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({sif.read_op, sif.write_op, sif.if_ack, sif.mem_ack} !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid_outputs: got %b want 0000", {sif.read_op, sif.write_op, sif.if_ack, sif.mem_ack});
        end
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL rstmid_state: got %0d want 0", dbg_state); end
        vectors++; if (sif.bus_addr !== '0) begin miscompares++; $display("FAIL rstmid_bus_addr: got %h want 0", sif.bus_addr); end
        step();
        rst = 1'b0;
        step();
        e = exp_q.pop_front();
        vectors++; if (sif.read_op !== 1'b1 || sif.bus_addr !== e[DW+AW-1:DW]) begin
            miscompares++; $display("FAIL rstmid_reissue: got read_op %b addr %h want 1 %h", sif.read_op, sif.bus_addr, e[DW+AW-1:DW]);
        end
        step();
        vectors++; if (sif.if_ack !== 1'b1 || sif.if_rdata !== e[DW-1:0]) begin
            miscompares++; $display("FAIL rstmid_ack: got ack %b data %h want 1 %h", sif.if_ack, sif.if_rdata, e[DW-1:0]);
        end
        sif.if_req = 1'b0;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        poke_en     = 1'b0;
        poke_addr   = '0;
        poke_data   = '0;
        idle_inputs();

        test_reset();
        test_lone_fetch();
        test_lone_write();
        test_stale_inputs();
        test_contention_pair();
        test_continuous();
        test_reset_mid_op();

        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
